bbox_tracker: RTL
=================

// Module: bbox_tracker
// PURPOSE
//   Per-frame bounding-box extractor for a thresholded camera mask stream.
//   Tracks min/max pixel coordinates and pixel count of asserted mask pixels
//   during a frame, then latches them on the new-frame pulse.
//   Sits directly upstream of the display/game stage and drives its
//   box_x/box_y/box_xmax/box_ymax inputs (one instance per tracked object).
// PARAMETERS
//   H_ACTIVE    960   columns accepted; pixels with hcount_in >= H_ACTIVE ignored
//   V_ACTIVE    640   rows accepted; pixels with vcount_in >= V_ACTIVE ignored
//   MIN_PIXELS  64    minimum mask pixel count for a frame's box to be valid
//   CNT_W       20    width of pixel counter; saturates at all-ones
// PORTS
//   clk_in          in   1      pixel clock
//   rst_in          in   1      asynchronous, active-high reset
//   hcount_in       in   11     pixel column
//   vcount_in       in   10     pixel row
//   valid_in        in   1      pixel qualifier; mask_in ignored when low
//   mask_in         in   1      1 = pixel belongs to tracked object
//   nf_in           in   1      single-cycle new-frame pulse
//   x_min_out       out  12     latched box left edge
//   y_min_out       out  11     latched box top edge
//   x_max_out       out  12     latched box right edge (inclusive)
//   y_max_out       out  11     latched box bottom edge (inclusive)
//   count_out       out  CNT_W  latched pixel count of last completed frame
//   box_valid_out   out  1      1 = last completed frame had count >= MIN_PIXELS
//   frame_done_out  out  1      1-cycle pulse, the cycle outputs update
// BEHAVIOUR
//   - Reset: all outputs 0; FSM -> SYNC; accumulators cleared.
//   - FSM SYNC: ignores pixels (mid-frame data discarded); on nf_in -> ACCUM,
//     accumulators seeded; no output update and no frame_done_out.
//   - FSM ACCUM: hit = valid_in & mask_in & hcount_in<H_ACTIVE & vcount_in<V_ACTIVE.
//     On hit: xmin=min(xmin,h), xmax=max(xmax,h), ymin/ymax likewise, cnt+=1
//     (saturating). Empty accumulator seed: xmin=H_ACTIVE-1, ymin=V_ACTIVE-1,
//     xmax=0, ymax=0, cnt=0.
//   - On nf_in in ACCUM: the cycle after, frame_done_out=1, count_out=cnt;
//     if cnt>=MIN_PIXELS: box outputs load, box_valid_out=1;
//     else box_valid_out=0, box outputs hold previous values.
//   - Latency: nf_in at cycle N -> outputs/frame_done_out visible at N+1.
//   - Simultaneous nf_in and hit: pixel belongs to the NEW frame; closing frame
//     uses accumulators before this cycle; new accumulators seeded with that pixel.
//   - Back-to-back nf_in: second closes an empty frame (cnt=0) -> box_valid_out=0.
//   - Coordinates zero-extended to output widths; no signed arithmetic outside
//     the smoothing path.
//   - Async reset mid-frame: immediate return to SYNC; next full frame needed.
// CONFIGURATION
//   BBOX_SMOOTH_EN defined: on valid-frame load, each edge e updates
//     e <= e + ((new - e) >>> 2), 13-bit signed difference, arithmetic shift,
//     result clipped to [0, H_ACTIVE-1] / [0, V_ACTIVE-1]. If box_valid_out was
//     0 before the load, edges load directly (no smoothing). count_out unsmoothed.
//   BBOX_SMOOTH_EN undefined: edges load directly every valid frame.
// TESTING
//   1 Reset, nf, 100 mask px spanning h 100..199, v 50 -> nf: outputs 100,50,199,50,
//     count 100, valid 1, frame_done pulse exactly 1 cycle after nf.
//   2 Following frame with 10 mask px (< MIN_PIXELS): count 10, valid 0, box
//     edges hold 100,50,199,50.
//   3 Mask px at h=960 and v=640 plus 64 px at (5,5): out-of-region ignored;
//     box 5,5,5,5, count 64, valid 1.
//   4 Mask px presented with nf_in in same cycle at (300,300): excluded from
//     closing frame, included in next frame's min/max.
//   5 Assert rst_in mid-frame, then pixels without nf: no frame_done; first nf
//     after reset produces no update; second nf updates.
//   6 BBOX_SMOOTH_EN: valid box x_min 0 then x_min 100 -> x_min_out 0 then 25;
//     same after an invalid frame -> loads 100 directly.

Source files
------------

// File: rtl/bbox_tracker_if.sv
// Pixel-stream and result bundle for bbox_tracker.
// The master drives the mask stream and observes the latched box; the tracker is the slave.
interface bbox_tracker_if #(
    parameter int CNT_W = 20
);
    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    logic             valid_in;
    logic             mask_in;
    logic             nf_in;
    logic [11:0]      x_min_out;
    logic [10:0]      y_min_out;
    logic [11:0]      x_max_out;
    logic [10:0]      y_max_out;
    logic [CNT_W-1:0] count_out;
    logic             box_valid_out;
    logic             frame_done_out;

    modport master (
        output hcount_in, vcount_in, valid_in, mask_in, nf_in,
        input  x_min_out, y_min_out, x_max_out, y_max_out,
        input  count_out, box_valid_out, frame_done_out
    );

    modport slave (
        input  hcount_in, vcount_in, valid_in, mask_in, nf_in,
        output x_min_out, y_min_out, x_max_out, y_max_out,
        output count_out, box_valid_out, frame_done_out
    );
endinterface

// File: rtl/bbox_tracker.sv
// Per-frame bounding box and pixel count of a thresholded mask stream, latched on nf_in.
// Optional feature: define BBOX_SMOOTH_EN to low-pass the box edges across valid frames.
module bbox_tracker #(
    parameter int H_ACTIVE   = 960,
    parameter int V_ACTIVE   = 640,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 20
) (
    input  logic          clk_in,
    input  logic          rst_in,
    bbox_tracker_if.slave bus,
    output logic          fsm_state_out
);
    typedef enum logic {
        SYNC  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [10:0]      H_LIM  = 11'(H_ACTIVE);
    localparam logic [9:0]       V_LIM  = 10'(V_ACTIVE);
    localparam logic [10:0]      H_SEED = 11'(H_ACTIVE - 1);
    localparam logic [9:0]       V_SEED = 10'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    state_t state, state_next;

    logic [10:0]      xmin, xmax;
    logic [9:0]       ymin, ymax;
    logic [CNT_W-1:0] cnt;

    logic hit, seed, close_frame, accum_en, frame_ok;

    // valid_in qualifies a pixel; there is no back-pressure, every qualified pixel is consumed.
    assign hit = bus.valid_in & bus.mask_in & (bus.hcount_in < H_LIM) & (bus.vcount_in < V_LIM);
    assign frame_ok = (cnt >= CNT_MIN);
    assign fsm_state_out = logic'(state);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= SYNC;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (bus.nf_in) state_next = ACCUM;
            ACCUM:   state_next = ACCUM;
            default: state_next = SYNC;
        endcase
    end

    always_comb begin
        seed        = 1'b0;
        close_frame = 1'b0;
        accum_en    = 1'b0;
        case (state)
            SYNC: seed = bus.nf_in;
            ACCUM: begin
                seed        = bus.nf_in;
                close_frame = bus.nf_in;
                accum_en    = hit & ~bus.nf_in;
            end
            default: ;
        endcase
    end

    // A pixel arriving with nf_in opens the new frame rather than closing the old one.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            xmin <= H_SEED;
            ymin <= V_SEED;
            xmax <= '0;
            ymax <= '0;
            cnt  <= '0;
        end else if (seed) begin
            if (hit) begin
                xmin <= bus.hcount_in;
                xmax <= bus.hcount_in;
                ymin <= bus.vcount_in;
                ymax <= bus.vcount_in;
                cnt  <= CNT_W'(1);
            end else begin
                xmin <= H_SEED;
                ymin <= V_SEED;
                xmax <= '0;
                ymax <= '0;
                cnt  <= '0;
            end
        end else if (accum_en) begin
            if (bus.hcount_in < xmin) xmin <= bus.hcount_in;
            if (bus.hcount_in > xmax) xmax <= bus.hcount_in;
            if (bus.vcount_in < ymin) ymin <= bus.vcount_in;
            if (bus.vcount_in > ymax) ymax <= bus.vcount_in;
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef BBOX_SMOOTH_EN
    // cur + floor((nxt - cur) / 4), kept inside [0, lim].
    function automatic logic [11:0] smooth_edge(input logic [11:0] cur,
                                                input logic [11:0] nxt,
                                                input logic [11:0] lim);
        logic signed [12:0] diff;
        logic signed [12:0] sum;
        diff = $signed({1'b0, nxt}) - $signed({1'b0, cur});
        sum  = $signed({1'b0, cur}) + (diff >>> 2);
        if (sum[12])                         return '0;
        else if (sum > $signed({1'b0, lim})) return lim;
        else                                 return sum[11:0];
    endfunction

    localparam logic [11:0] X_CLIP = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_CLIP = 12'(V_ACTIVE - 1);
    logic [11:0] x_min_s, x_max_s, y_min_s, y_max_s;

    always_comb begin
        x_min_s = smooth_edge(bus.x_min_out, {1'b0, xmin}, X_CLIP);
        x_max_s = smooth_edge(bus.x_max_out, {1'b0, xmax}, X_CLIP);
        y_min_s = smooth_edge({1'b0, bus.y_min_out}, {2'b0, ymin}, Y_CLIP);
        y_max_s = smooth_edge({1'b0, bus.y_max_out}, {2'b0, ymax}, Y_CLIP);
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.x_min_out      <= '0;
            bus.y_min_out      <= '0;
            bus.x_max_out      <= '0;
            bus.y_max_out      <= '0;
            bus.count_out      <= '0;
            bus.box_valid_out  <= 1'b0;
            bus.frame_done_out <= 1'b0;
        end else begin
            bus.frame_done_out <= close_frame;
            if (close_frame) begin
                bus.count_out     <= cnt;
                bus.box_valid_out <= frame_ok;
                if (frame_ok) begin
`ifdef BBOX_SMOOTH_EN
                    if (bus.box_valid_out) begin
                        bus.x_min_out <= x_min_s;
                        bus.x_max_out <= x_max_s;
                        bus.y_min_out <= y_min_s[10:0];
                        bus.y_max_out <= y_max_s[10:0];
                    end else begin
                        bus.x_min_out <= {1'b0, xmin};
                        bus.x_max_out <= {1'b0, xmax};
                        bus.y_min_out <= {1'b0, ymin};
                        bus.y_max_out <= {1'b0, ymax};
                    end
`else
                    bus.x_min_out <= {1'b0, xmin};
                    bus.x_max_out <= {1'b0, xmax};
                    bus.y_min_out <= {1'b0, ymin};
                    bus.y_max_out <= {1'b0, ymax};
`endif
                end
            end
        end
    end
endmodule
